vscale_lsu: RTL and testbench
=============================

Name: vscale_lsu

Overview:
- Parametrised load/store unit between the DX/WB pipeline stages and the data-memory port.
- Generalises the fixed 32-bit store replication and load extension to XLEN=32/64, adding per-byte write enables, misalignment faults and a DEPTH-entry in-order response FIFO with backpressure.
- Memory side uses the existing split address/data-phase protocol: wdata is driven in the data phase, and mem_wait stretches the data phase.

Parameters:
- XLEN, 32: datapath and address width; 32 or 64 only.
- DEPTH, 2: response FIFO entries; power of two, ≥2.
- TAG_W, 5: width of the destination-register tag carried with each request.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_wen  in  1  1 = store, 0 = load.
- req_type  in  3  {B,H,W,D}=0..3 signed; {BU,HU,WU}=4..6; D and WU are illegal when XLEN=32.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, low bits significant.
- req_tag  in  TAG_W  rd tag, returned unchanged.
- resp_valid  out  1  response at FIFO head.
- resp_ready  in  1  consumer takes the head.
- resp_data  out  XLEN  formatted load data; 0 for stores and faults.
- resp_tag  out  TAG_W  tag of the head entry.
- resp_wen  out  1  entry was a store.
- resp_fault  out  2  0 = ok, 1 = misaligned, 2 = bus error, 3 = illegal type.
- mem_en  out  1  address phase valid.
- mem_wen  out  1  address phase is a write.
- mem_addr  out  XLEN  address aligned to XLEN/8.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data, driven during the data phase.
- mem_wait  in  1  extends the current data phase.
- mem_rdata  in  XLEN  read data, sampled at the end of the data phase.
- mem_badmem_e  in  1  bus error, sampled with mem_rdata.

Behaviour:
- Reset (async assert, sync deassert): FIFO empty, in-flight slot clear, all outputs 0 except req_ready, which is 1 once reset deasserts. Asserting reset_n mid-transaction discards the in-flight slot and all FIFO contents; no further memory phases are driven for them.
- Credits: count = FIFO occupancy + in-flight (0/1).
  - req_ready = !mem_wait && (count < DEPTH || (resp_valid && resp_ready && count == DEPTH)).
  - Pop and push in the same cycle are both legal.
- Address phase is the acceptance cycle, combinational from the req_* inputs:
  - mem_en = accept && ok, where ok = aligned && legal type.
  - mem_addr = req_addr with the low log2(XLEN/8) bits cleared.
  - mem_be = size mask (1/3/F/FF) << offset.
- Alignment: offset must be a multiple of the access size; byte accesses are always aligned.
- Misaligned or illegal requests are still accepted and occupy the in-flight slot, with mem_en=0, so response order is preserved.
- In-flight slot: loaded on accept with addr, type, tag, wen, fault and wdata.
  - Data phase is the cycle after acceptance, repeated while mem_wait=1.
  - mem_wdata is held stable throughout the data phase.
  - The slot completes in the first data-phase cycle with mem_wait=0 and pushes one FIFO entry.
  - Fault entries never drive the bus and complete in one cycle, ignoring mem_wait.
- Back-to-back: an accept may coincide with the completing data phase; this gives a one-request-per-cycle throughput.
- Store data: B replicated XLEN/8 times, H replicated XLEN/16 times, W replicated XLEN/32 times, D passed through.
- Load data: mem_rdata >> (offset·8), then masked to the access size and sign- or zero-extended per req_type.
- Bus error: mem_badmem_e=1 at completion gives resp_fault=2 and resp_data=0.
- FIFO: circular, log2(DEPTH)-bit pointers plus a full flag; pointers wrap at DEPTH.
  - resp_* outputs are driven from the head entry.
  - resp_* must stay stable while resp_valid && !resp_ready.
- mem_wait=1 with the in-flight slot empty has no effect other than deasserting req_ready.

Test Plan:
- XLEN=32, LB addr 0x103, mem_rdata 0x80FF_0000 -> mem_addr 0x100, mem_be 0x8, resp_data 0xFFFF_FF80; LBU of the same -> 0x0000_0080.
- XLEN=64, SH addr 0x206, wdata 0x1234 -> mem_be 0xC0, mem_wdata 0x1234_1234_1234_1234 in the data phase; resp_wen=1, resp_fault=0.
- LW addr 0x102 -> mem_en stays 0, resp_fault=1, resp_data=0, tag preserved; a load accepted before it on the next-to-last cycle responds first.
- DEPTH=2, resp_ready=0, three loads offered -> only two accepted, req_ready=0; one resp_ready pulse pops the head and the third is accepted in that same cycle.
- mem_wait high 3 cycles during a store data phase -> mem_wdata stable 4 cycles, req_ready=0 throughout, exactly one response.
- reset_n low mid data phase with 1 FIFO entry -> resp_valid=0 and mem_en=0 immediately; after release, count=0 and req_ready=1.

Source files
------------

// File: rtl/vscale_lsu.sv
// Load/store unit between the DX/WB pipeline stages and a split-phase data-memory port.
// Requests go through one in-flight slot and then a DEPTH-entry in-order response FIFO.
module vscale_lsu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_type,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_wen,
  output logic [1:0]        resp_fault,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_wait,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_badmem_e
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 2;

  logic              rst_done;
  logic              slot_valid, slot_wen;
  logic [2:0]        slot_type;
  logic [OFFW-1:0]   slot_off;
  logic [TAG_W-1:0]  slot_tag;
  logic [1:0]        slot_fault;
  logic [XLEN-1:0]   slot_wdata;

  logic [XLEN-1:0]   fifo_data  [DEPTH];
  logic [TAG_W-1:0]  fifo_tag   [DEPTH];
  logic              fifo_wen   [DEPTH];
  logic [1:0]        fifo_fault [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt, ptr_diff;
  logic              full, empty, pop, accept, slot_done;
  logic [CW-1:0]     fifo_cnt, count;

  logic [1:0]        req_size;
  logic [OFFW-1:0]   req_off, align_mask;
  logic              illegal, misaligned;
  logic [1:0]        req_fault;
  logic [NB-1:0]     size_mask;
  logic [XLEN-1:0]   store_rep;

  logic [XLEN-1:0]   shifted, load_mask, load_data, push_data;
  logic              sbit;
  logic [1:0]        push_fault;

  // Credit accounting: FIFO occupancy plus the in-flight slot.
  assign empty    = (wr_ptr == rd_ptr) && !full;
  assign ptr_diff = wr_ptr - rd_ptr;
  assign wr_nxt   = wr_ptr + PW'(1);
  assign rd_nxt   = rd_ptr + PW'(1);
  assign fifo_cnt = full ? CW'(DEPTH) : {2'b00, ptr_diff};
  assign count    = fifo_cnt + CW'(slot_valid);
  assign pop      = resp_valid && resp_ready;
  assign req_ready = rst_done && !mem_wait &&
                     ((count < CW'(DEPTH)) || (pop && (count == CW'(DEPTH))));
  assign accept   = req_valid && req_ready;

  assign req_size   = req_type[1:0];
  assign req_off    = req_addr[OFFW-1:0];
  assign align_mask = OFFW'((32'd1 << req_size) - 32'd1);
  assign misaligned = |(req_off & align_mask);
  assign illegal    = (req_type == 3'd7) ||
                      ((XLEN == 32) && ((req_type == 3'd3) || (req_type == 3'd6)));
  assign req_fault  = illegal ? 2'd3 : (misaligned ? 2'd1 : 2'd0);

  always_comb begin
    size_mask = '1;
    store_rep = req_wdata;
    case (req_size)
      2'd0: begin size_mask = NB'(1);  store_rep = {NB{req_wdata[7:0]}};          end
      2'd1: begin size_mask = NB'(3);  store_rep = {(XLEN/16){req_wdata[15:0]}};  end
      2'd2: begin size_mask = NB'(15); store_rep = {(XLEN/32){req_wdata[31:0]}};  end
      default: ;
    endcase
  end

  assign mem_en   = accept && (req_fault == 2'd0);
  assign mem_wen  = mem_en && req_wen;
  assign mem_addr = mem_en ? {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_be   = mem_en ? (size_mask << req_off) : '0;

  // Fault entries never touch the bus, so they retire regardless of mem_wait.
  assign slot_done = slot_valid && ((slot_fault != 2'd0) || !mem_wait);
  assign mem_wdata = (slot_valid && slot_wen && (slot_fault == 2'd0)) ? slot_wdata : '0;

  assign shifted = mem_rdata >> {slot_off, 3'b000};
  always_comb begin
    load_mask = '1;
    sbit      = shifted[XLEN-1];
    case (slot_type[1:0])
      2'd0: begin load_mask = XLEN'(8'hFF);         sbit = shifted[7];  end
      2'd1: begin load_mask = XLEN'(16'hFFFF);      sbit = shifted[15]; end
      2'd2: begin load_mask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: ;
    endcase
  end
  assign load_data  = (shifted & load_mask) | ((!slot_type[2] && sbit) ? ~load_mask : '0);
  assign push_fault = (slot_fault != 2'd0) ? slot_fault : (mem_badmem_e ? 2'd2 : 2'd0);
  assign push_data  = (slot_wen || (push_fault != 2'd0)) ? '0 : load_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_done   <= 1'b0;
      slot_valid <= 1'b0;
      slot_wen   <= 1'b0;
      slot_type  <= '0;
      slot_off   <= '0;
      slot_tag   <= '0;
      slot_fault <= '0;
      slot_wdata <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full       <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        slot_valid <= 1'b1;
        slot_wen   <= req_wen;
        slot_type  <= req_type;
        slot_off   <= req_off;
        slot_tag   <= req_tag;
        slot_fault <= req_fault;
        slot_wdata <= store_rep;
      end else if (slot_done) begin
        slot_valid <= 1'b0;
      end
      if (slot_done) wr_ptr <= wr_nxt;
      if (pop)       rd_ptr <= rd_nxt;
      if (slot_done && !pop)      full <= (wr_nxt == rd_ptr);
      else if (pop && !slot_done) full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (slot_done) begin
      fifo_data[wr_ptr]  <= push_data;
      fifo_tag[wr_ptr]   <= slot_tag;
      fifo_wen[wr_ptr]   <= slot_wen;
      fifo_fault[wr_ptr] <= push_fault;
    end
  end

  assign resp_valid = !empty;
  assign resp_data  = resp_valid ? fifo_data[rd_ptr]  : '0;
  assign resp_tag   = resp_valid ? fifo_tag[rd_ptr]   : '0;
  assign resp_wen   = resp_valid ? fifo_wen[rd_ptr]   : 1'b0;
  assign resp_fault = resp_valid ? fifo_fault[rd_ptr] : 2'd0;
endmodule

// File: tb/tb_vscale_lsu.sv
// Bench for vscale_lsu: XLEN=64 instance against a transaction-level model,
// plus a small XLEN=32 instance for narrow-datapath formatting and illegal types.
module tb_vscale_lsu;
  localparam int XL = 64;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_wen = 0;
  logic [2:0]  req_type = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [4:0]  req_tag = 0;
  logic        resp_valid, resp_ready = 0;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_wen;
  logic [1:0]  resp_fault;
  logic        mem_en, mem_wen;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_wait = 0;
  logic [63:0] mem_rdata = 0;
  logic        mem_badmem_e = 0;

  logic        s_req_valid = 0, s_req_ready, s_req_wen = 0;
  logic [2:0]  s_req_type = 0;
  logic [31:0] s_req_addr = 0, s_req_wdata = 0;
  logic [4:0]  s_req_tag = 0;
  logic        s_resp_valid, s_resp_ready = 1;
  logic [31:0] s_resp_data;
  logic [4:0]  s_resp_tag;
  logic        s_resp_wen;
  logic [1:0]  s_resp_fault;
  logic        s_mem_en, s_mem_wen;
  logic [31:0] s_mem_addr;
  logic [3:0]  s_mem_be;
  logic [31:0] s_mem_wdata;
  logic        s_mem_wait = 0;
  logic [31:0] s_mem_rdata = 0;
  logic        s_mem_badmem_e = 0;

  vscale_lsu #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(5)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_wen(resp_wen), .resp_fault(resp_fault),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_wait(mem_wait), .mem_rdata(mem_rdata),
    .mem_badmem_e(mem_badmem_e)
  );

  vscale_lsu #(.XLEN(32), .DEPTH(2), .TAG_W(5)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wen(s_req_wen), .req_type(s_req_type),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_tag(s_req_tag),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_data(s_resp_data),
    .resp_tag(s_resp_tag), .resp_wen(s_resp_wen), .resp_fault(s_resp_fault),
    .mem_en(s_mem_en), .mem_wen(s_mem_wen), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
    .mem_wdata(s_mem_wdata), .mem_wait(s_mem_wait), .mem_rdata(s_mem_rdata),
    .mem_badmem_e(s_mem_badmem_e)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        wen;
    logic [1:0]  fault;
  } resp_t;

  typedef struct {
    bit          valid;
    logic        wen;
    logic [2:0]  typ;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  tag;
    logic [1:0]  fault;
  } req_t;

  resp_t exp_q[$];
  req_t  infl;

  function automatic int sz_bytes(input logic [2:0] t);
    case (t)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [63:0] m_mask(input int nbytes);
    if (nbytes == 8) return '1;
    return (64'd1 << (8 * nbytes)) - 64'd1;
  endfunction

  function automatic logic [1:0] m_fault(input logic [2:0] t, input logic [63:0] a, input int xl);
    if (t == 3'd7 || (xl == 32 && (t == 3'd3 || t == 3'd6))) return 2'd3;
    if ((a % 64'(sz_bytes(t))) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] m_be(input logic [2:0] t, input logic [63:0] a, input int xl);
    return ((64'd1 << sz_bytes(t)) - 64'd1) << (a % 64'(xl / 8));
  endfunction

  function automatic logic [63:0] m_store(input logic [2:0] t, input logic [63:0] wd, input int xl);
    logic [63:0] r = 0;
    int sz = sz_bytes(t);
    for (int i = 0; i < xl / (8 * sz); i++) r |= (wd & m_mask(sz)) << (i * 8 * sz);
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] t, input logic [63:0] a,
                                         input logic [63:0] rd, input int xl);
    int sz = sz_bytes(t);
    logic [63:0] mk = m_mask(sz);
    logic [63:0] v = (rd >> (8 * (a % 64'(xl / 8)))) & mk;
    if (t < 3'd4 && v[8 * sz - 1]) v |= ~mk;
    if (xl == 32) v &= 64'hFFFF_FFFF;
    return v;
  endfunction

  // One clock cycle of stimulus on the 64-bit instance, checked against the model.
  task automatic step(input logic v, input logic wen, input logic [2:0] t, input logic [63:0] a,
                      input logic [63:0] wd, input logic [4:0] tg, input logic rr,
                      input logic mw, input logic [63:0] rd, input logic bad);
    resp_t e;
    logic exp_ready, pop, acc, done;
    logic [1:0] f;
    int cnt;
    @(negedge clk);
    req_valid = v; req_wen = wen; req_type = t; req_addr = a; req_wdata = wd; req_tag = tg;
    resp_ready = rr; mem_wait = mw; mem_rdata = rd; mem_badmem_e = bad;
    #1;
    check("resp_valid", resp_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("resp_data", resp_data, exp_q[0].data);
      check("resp_tag", resp_tag, exp_q[0].tag);
      check("resp_wen", resp_wen, exp_q[0].wen);
      check("resp_fault", resp_fault, exp_q[0].fault);
    end
    pop = (exp_q.size() > 0) && rr;
    cnt = exp_q.size() + (infl.valid ? 1 : 0);
    exp_ready = !mw && (cnt < DEPTH || (pop && cnt == DEPTH));
    check("req_ready", req_ready, exp_ready);
    acc = v && exp_ready;
    f = m_fault(t, a, XL);
    check("mem_en", mem_en, acc && f == 2'd0);
    if (acc && f == 2'd0) begin
      check("mem_wen", mem_wen, wen);
      check("mem_addr", mem_addr, a & ~64'h7);
      check("mem_be", mem_be, m_be(t, a, XL));
    end
    if (infl.valid && infl.wen && infl.fault == 2'd0)
      check("mem_wdata", mem_wdata, m_store(infl.typ, infl.wdata, XL));
    done = infl.valid && (infl.fault != 2'd0 || !mw);
    if (pop) void'(exp_q.pop_front());
    if (done) begin
      e.tag = infl.tag;
      e.wen = infl.wen;
      e.fault = (infl.fault != 2'd0) ? infl.fault : (bad ? 2'd2 : 2'd0);
      e.data = (infl.wen || e.fault != 2'd0) ? 64'd0 : m_load(infl.typ, infl.addr, rd, XL);
      exp_q.push_back(e);
    end
    if (acc) begin
      infl.valid = 1'b1; infl.wen = wen; infl.typ = t; infl.addr = a;
      infl.wdata = wd; infl.tag = tg; infl.fault = f;
    end else if (done) begin
      infl.valid = 1'b0;
    end
  endtask

  task automatic idle(input logic rr, input logic [63:0] rd);
    step(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, rr, 1'b0, rd, 1'b0);
  endtask

  task automatic req32(input string nm, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] rd, input logic exp_en, input logic [3:0] exp_be,
                       input logic [31:0] exp_data, input logic [1:0] exp_f);
    @(negedge clk);
    s_req_valid = 1'b1; s_req_type = t; s_req_addr = a; s_resp_ready = 1'b1; s_mem_wait = 1'b0;
    #1;
    check({nm, "_ready"}, s_req_ready, 1'b1);
    check({nm, "_en"}, s_mem_en, exp_en);
    if (exp_en) begin
      check({nm, "_addr"}, s_mem_addr, a & ~32'h3);
      check({nm, "_be"}, s_mem_be, exp_be);
    end
    @(negedge clk);
    s_req_valid = 1'b0; s_mem_rdata = rd;
    @(negedge clk);
    #1;
    check({nm, "_rvalid"}, s_resp_valid, 1'b1);
    check({nm, "_rdata"}, s_resp_data, exp_data);
    check({nm, "_rdata_model"}, s_resp_data,
          (exp_f == 2'd0) ? m_load(t, 64'(a), 64'(rd), 32) : 64'd0);
    check({nm, "_rfault"}, s_resp_fault, exp_f);
  endtask

  initial begin
    infl.valid = 1'b0;
    #2 reset_n = 1'b0;
    req_valid = 1'b1; req_type = 3'd2; req_addr = 64'h40;
    #20;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_be", mem_be, 8'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_resp_data", resp_data, 64'h0);
    req_valid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    idle(1'b1, 64'd0);
    check("post_rst_ready", req_ready, 1'b1);

    // SH at 0x206 on the 64-bit datapath
    step(1, 1, 3'd1, 64'h206, 64'h1234, 5'd3, 1, 0, 64'd0, 0);
    check("sh_be", mem_be, 8'hC0);
    idle(1'b1, 64'd0);
    check("sh_wdata", mem_wdata, 64'h1234_1234_1234_1234);
    idle(1'b1, 64'd0);
    check("sh_resp_wen", resp_wen, 1'b1);
    check("sh_resp_fault", resp_fault, 2'd0);

    // LB / LBU at 0x103
    step(1, 0, 3'd0, 64'h103, 64'd0, 5'd4, 1, 0, 64'd0, 0);
    check("lb_addr", mem_addr, 64'h100);
    check("lb_be", mem_be, 8'h08);
    idle(1'b1, 64'h80FF_0000);
    idle(1'b1, 64'd0);
    check("lb_data", resp_data, 64'hFFFF_FFFF_FFFF_FF80);
    step(1, 0, 3'd4, 64'h103, 64'd0, 5'd5, 1, 0, 64'd0, 0);
    idle(1'b1, 64'h80FF_0000);
    idle(1'b1, 64'd0);
    check("lbu_data", resp_data, 64'h80);

    // Aligned LD followed by misaligned LW keeps order
    step(1, 0, 3'd3, 64'h40, 64'd0, 5'd5, 1, 0, 64'd0, 0);
    step(1, 0, 3'd2, 64'h102, 64'd0, 5'd6, 1, 0, 64'h1111_2222_3333_4444, 0);
    check("mis_mem_en", mem_en, 1'b0);
    idle(1'b1, 64'd0);
    check("mis_first_tag", resp_tag, 5'd5);
    idle(1'b1, 64'd0);
    check("mis_tag", resp_tag, 5'd6);
    check("mis_fault", resp_fault, 2'd1);
    check("mis_data", resp_data, 64'd0);

    // Backpressure with a full FIFO
    step(1, 0, 3'd2, 64'h10, 64'd0, 5'd7, 0, 0, 64'd0, 0);
    step(1, 0, 3'd2, 64'h14, 64'd0, 5'd8, 0, 0, 64'hA, 0);
    step(1, 0, 3'd2, 64'h18, 64'd0, 5'd9, 0, 0, 64'hB, 0);
    check("bp_stall1", req_ready, 1'b0);
    step(1, 0, 3'd2, 64'h18, 64'd0, 5'd9, 0, 0, 64'hC, 0);
    check("bp_stall2", req_ready, 1'b0);
    step(1, 0, 3'd2, 64'h18, 64'd0, 5'd9, 1, 0, 64'hD, 0);
    check("bp_pop_accept", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 64'hE);

    // Store data phase stretched by mem_wait
    step(1, 1, 3'd2, 64'h80, 64'hDEAD_BEEF, 5'd10, 1, 0, 64'd0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 3'd0, 64'd0, 64'd0, 5'd0, 1, (i < 3), 64'd0, 0);
      check("wait_wdata", mem_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
      if (i < 3) check("wait_ready", req_ready, 1'b0);
    end
    idle(1'b1, 64'd0);
    check("wait_one_resp", resp_tag, 5'd10);
    idle(1'b1, 64'd0);
    check("wait_no_second", resp_valid, 1'b0);

    // Reset in the middle of a data phase with one FIFO entry
    step(1, 0, 3'd2, 64'h20, 64'd0, 5'd11, 0, 0, 64'd0, 0);
    step(1, 0, 3'd2, 64'h24, 64'd0, 5'd12, 0, 0, 64'h5, 0);
    step(0, 0, 3'd0, 64'd0, 64'd0, 5'd0, 0, 1, 64'd0, 0);
    reset_n = 1'b0; mem_wait = 1'b0; req_valid = 1'b1; req_type = 3'd2; req_addr = 64'h28;
    #1;
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_mem_en", mem_en, 1'b0);
    exp_q.delete();
    infl.valid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    idle(1'b0, 64'd0);
    check("mid_rst_ready", req_ready, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [63:0] a;
      a = {$urandom(), $urandom()};
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), a,
           {$urandom(), $urandom()}, 5'($urandom()), $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) == 0, {$urandom(), $urandom()}, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1, 64'd0);
    check("drain_empty", resp_valid, 1'b0);

    // Narrow datapath
    req32("lb32",  3'd0, 32'h103, 32'h80FF_0000, 1, 4'h8, 32'hFFFF_FF80, 2'd0);
    req32("lbu32", 3'd4, 32'h103, 32'h80FF_0000, 1, 4'h8, 32'h0000_0080, 2'd0);
    req32("lh32",  3'd1, 32'h102, 32'h80FF_0000, 1, 4'hC, 32'hFFFF_80FF, 2'd0);
    req32("lw32",  3'd2, 32'h100, 32'h1234_5678, 1, 4'hF, 32'h1234_5678, 2'd0);
    req32("ld32",  3'd3, 32'h100, 32'h1234_5678, 0, 4'h0, 32'h0, 2'd3);
    req32("lwu32", 3'd6, 32'h100, 32'h1234_5678, 0, 4'h0, 32'h0, 2'd3);
    req32("mish32", 3'd1, 32'h101, 32'h1234_5678, 0, 4'h0, 32'h0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
